channel_error_injector: RTL and testbench

//  Parametrised bit-error channel between convolutional encoder and Viterbi decoder.

---
 rtl/channel_error_injector.sv | 191 +++++++++++++++++++
 tb/tb_channel_error_injector.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_error_injector.sv
// ============================================================================
// Module  : channel_error_injector
// Purpose : Bit-error channel placed between a convolutional encoder and a
//           Viterbi decoder. Each W-bit coded symbol is registered. An error
//           mask is XORed onto the symbols selected by the active mode:
//           off, periodic, burst or LFSR pseudo-random. Injection only happens
//           inside a symbol window. Injected symbols and flipped bits are
//           counted.
// Option  : CHAN_ERR_BITCOUNT_EN - when defined, flipped bits are counted on
//           err_bit_ct_o. When undefined, err_bit_ct_o is tied to zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module channel_error_injector #(
  parameter int          W      = 2,
  parameter int          P      = 4,
  parameter int          BL_W   = 4,
  parameter int          WINDOW = 256,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [W-1:0]    sym_i,
  input  logic [1:0]      mode_i,
  input  logic [W-1:0]    err_mask_i,
  input  logic [BL_W-1:0] burst_len_i,
  input  logic [7:0]      thresh_i,
  output logic            valid_o,
  output logic [W-1:0]    sym_o,
  output logic            err_o,
  output logic [15:0]     sym_ct_o,
  output logic [15:0]     err_sym_ct_o,
  output logic [15:0]     err_bit_ct_o
);

  localparam logic [1:0] MODE_OFF      = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;
  localparam logic [1:0] MODE_BURST    = 2'b10;
  localparam logic [1:0] MODE_RANDOM   = 2'b11;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state;
  logic [BL_W-1:0] burst_rem;
  logic [15:0]     sym_ct;
  logic [15:0]     lfsr;
  logic [15:0]     err_sym_ct;

  logic            trg;
  logic            win;
  logic            inj;
  logic            burst_start;
  logic            lfsr_fb;
  logic [15:0]     lfsr_nxt;

  // The trigger fires on the last symbol of every 2**P block of the count.
  assign trg = &sym_ct[P-1:0];

  // A window of 0 means injection is never limited by the symbol count.
  assign win = (WINDOW == 0) || (32'(sym_ct) < WINDOW);

  // A burst may only start from IDLE, on a trigger, and with a nonzero length.
  assign burst_start = (state == IDLE) && trg && (burst_len_i != '0);

  // Fibonacci LFSR for x^16+x^14+x^13+x^11+1 in right-shift form.
  assign lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign lfsr_nxt = {lfsr_fb, lfsr[15:1]};

  // Decide whether the current accepted symbol gets the error mask.
  always_comb begin
    inj = 1'b0;
    if (valid_i && win) begin
      case (mode_i)
        MODE_OFF:      inj = 1'b0;
        MODE_PERIODIC: inj = trg;
        MODE_BURST:    inj = (state == BURST) || burst_start;
        MODE_RANDOM:   inj = (lfsr[7:0] < thresh_i);
        default:       inj = 1'b0;
      endcase
    end
  end

  // Burst FSM: runs only while in burst mode inside the window.
  // Leaving burst mode or the window returns it to IDLE on the next symbol.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      burst_rem <= '0;
    end else if (valid_i) begin
      if (!win || (mode_i != MODE_BURST)) begin
        state     <= IDLE;
        burst_rem <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (burst_start) begin
              burst_rem <= burst_len_i - 1'b1;
              state     <= (burst_len_i != BL_W'(1)) ? BURST : IDLE;
            end
          end
          BURST: begin
            burst_rem <= burst_rem - 1'b1;
            state     <= (burst_rem != BL_W'(1)) ? BURST : IDLE;
          end
          default: begin
            state     <= IDLE;
            burst_rem <= '0;
          end
        endcase
      end
    end
  end

  // Symbol count and LFSR advance once per accepted symbol, in every mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_ct <= '0;
      lfsr   <= SEED;
    end else if (valid_i) begin
      if (sym_ct != 16'hFFFF) begin
        sym_ct <= sym_ct + 16'd1;
      end
      lfsr <= lfsr_nxt;
    end
  end

  // Output stage: a one-cycle registered channel. Symbol and error flag hold
  // across invalid cycles, while valid_o simply follows valid_i.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o <= 1'b0;
      sym_o   <= '0;
      err_o   <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        sym_o <= sym_i ^ (inj ? err_mask_i : '0);
        err_o <= inj;
      end
    end
  end

  // Count corrupted symbols, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_sym_ct <= '0;
    end else if (inj && (err_sym_ct != 16'hFFFF)) begin
      err_sym_ct <= err_sym_ct + 16'd1;
    end
  end

  assign sym_ct_o     = sym_ct;
  assign err_sym_ct_o = err_sym_ct;

`ifdef CHAN_ERR_BITCOUNT_EN
  logic [15:0] err_bit_ct;
  logic [15:0] mask_pop;
  logic [16:0] bit_sum;

  // Count the bits set in the error mask.
  always_comb begin
    mask_pop = '0;
    for (int i = 0; i < W; i++) begin
      mask_pop = mask_pop + {15'd0, err_mask_i[i]};
    end
  end

  assign bit_sum = {1'b0, err_bit_ct} + {1'b0, mask_pop};

  // Accumulate the flipped bits of each injected symbol, saturating on carry-out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_bit_ct <= '0;
    end else if (inj) begin
      err_bit_ct <= bit_sum[16] ? 16'hFFFF : bit_sum[15:0];
    end
  end

  assign err_bit_ct_o = err_bit_ct;
`else
  assign err_bit_ct_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_channel_error_injector.sv
// ============================================================================
// Module  : tb_channel_error_injector
// Purpose : Directed testbench for channel_error_injector. A behavioural
//           channel model is compared with the DUT on every cycle.
//           Hand-computed literal values pin the model itself.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_channel_error_injector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid_i = 1'b0;
  logic [1:0] sym_i = 2'b00;
  logic [1:0] mode_i = 2'b00;
  logic [1:0] err_mask_i = 2'b00;
  logic [3:0] burst_len_i = 4'd0;
  logic [7:0] thresh_i = 8'd0;

  logic        valid_o;
  logic [1:0]  sym_o;
  logic        err_o;
  logic [15:0] sym_ct_o;
  logic [15:0] err_sym_ct_o;
  logic [15:0] err_bit_ct_o;

  int errors = 0;
  int checks = 0;

  channel_error_injector dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .sym_i        (sym_i),
    .mode_i       (mode_i),
    .err_mask_i   (err_mask_i),
    .burst_len_i  (burst_len_i),
    .thresh_i     (thresh_i),
    .valid_o      (valid_o),
    .sym_o        (sym_o),
    .err_o        (err_o),
    .sym_ct_o     (sym_ct_o),
    .err_sym_ct_o (err_sym_ct_o),
    .err_bit_ct_o (err_bit_ct_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural channel model ----------------
  // State is held as plain integers: how many symbols have been accepted,
  // how many burst symbols are still owed, and the current pseudo-random word.
  int        m_count = 0;
  int        m_owed = 0;
  int        m_lfsr = 'hACE1;
  logic      e_valid = 1'b0;
  logic [1:0] e_sym = 2'b00;
  logic      e_err = 1'b0;
  int        e_esc = 0;
  int        e_ebc = 0;

  function automatic int next_lfsr(input int v);
    int b;
    b = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return (v >> 1) | (b << 15);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_count = 0; m_owed = 0; m_lfsr = 'hACE1;
      e_valid = 1'b0; e_sym = 2'b00; e_err = 1'b0; e_esc = 0; e_ebc = 0;
    end else begin
      e_valid = valid_i;
      if (valid_i) begin
        bit in_win;
        bit hit;
        bit block_end;
        in_win    = (m_count < 256);
        block_end = ((m_count % 16) == 15);
        hit       = 1'b0;
        if (mode_i != 2'b10 || !in_win) m_owed = 0;
        if (in_win) begin
          case (mode_i)
            2'b01: hit = block_end;
            2'b10: begin
              if (m_owed == 0 && block_end) m_owed = int'(burst_len_i);
              if (m_owed > 0) begin hit = 1'b1; m_owed--; end
            end
            2'b11: hit = ((m_lfsr % 256) < int'(thresh_i));
            default: hit = 1'b0;
          endcase
        end
        e_sym = hit ? (sym_i ^ err_mask_i) : sym_i;
        e_err = hit;
        if (hit) begin
          e_esc = (e_esc + 1 > 65535) ? 65535 : e_esc + 1;
`ifdef CHAN_ERR_BITCOUNT_EN
          e_ebc = (e_ebc + $countones(err_mask_i) > 65535) ? 65535 : e_ebc + $countones(err_mask_i);
`endif
        end
        m_count = (m_count == 65535) ? 65535 : m_count + 1;
        m_lfsr  = next_lfsr(m_lfsr);
      end
    end
  end

  // Compare the DUT against the model on every falling edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("valid_o", 32'(valid_o), 32'(e_valid));
      chk("sym_o", 32'(sym_o), 32'(e_sym));
      chk("err_o", 32'(err_o), 32'(e_err));
      chk("sym_ct_o", 32'(sym_ct_o), 32'(m_count));
      chk("err_sym_ct_o", 32'(err_sym_ct_o), e_esc);
      chk("err_bit_ct_o", 32'(err_bit_ct_o), e_ebc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Assert reset asynchronously, check outputs clear at once, then release.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_sym", 32'(sym_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_sym_ct", 32'(sym_ct_o), 32'd0);
    chk("rst_err_sym_ct", 32'(err_sym_ct_o), 32'd0);
    cyc(1);
    rst = 1'b1;
  endtask

  initial begin
    cyc(2);
    do_reset();

    // Periodic single error: mask 01 on symbol 2'b10, window ends at 256.
    mode_i = 2'b01; err_mask_i = 2'b01; sym_i = 2'b10; valid_i = 1'b1;
    cyc(16);
    chk("per_sym15_sym", 32'(sym_o), 32'd3);
    chk("per_sym15_err", 32'(err_o), 32'd1);
    cyc(284);
    chk("per_err_sym_ct", 32'(err_sym_ct_o), 32'd16);
    chk("per_sym_ct", 32'(sym_ct_o), 32'd300);
`ifdef CHAN_ERR_BITCOUNT_EN
    chk("per_err_bit_ct", 32'(err_bit_ct_o), 32'd16);
`else
    chk("per_err_bit_ct", 32'(err_bit_ct_o), 32'd0);
`endif

    // Burst of 3, mask 11. Bursts start at 15,31..239 and run in full.
    // The burst starting at 255 is cut to one symbol by the window: 15*3+1.
    do_reset();
    mode_i = 2'b10; burst_len_i = 4'd3; err_mask_i = 2'b11; sym_i = 2'b01;
    cyc(260);
    chk("burst_err_sym_ct", 32'(err_sym_ct_o), 32'd46);

    // Burst aborted by a mode change on symbol 16.
    do_reset();
    mode_i = 2'b10;
    cyc(16);
    mode_i = 2'b00;
    cyc(4);
    chk("abort_err_sym_ct", 32'(err_sym_ct_o), 32'd1);
    mode_i = 2'b10;
    cyc(12);
    chk("abort_next_burst", 32'(err_sym_ct_o), 32'd2);

    // Random mode. Seed low byte is 8'hE1 = 225.
    do_reset();
    mode_i = 2'b11; thresh_i = 8'd226;
    cyc(1);
    chk("rnd_seed_hit", 32'(err_o), 32'd1);
    do_reset();
    thresh_i = 8'd225;
    cyc(1);
    chk("rnd_seed_miss", 32'(err_o), 32'd0);
    do_reset();
    thresh_i = 8'd0;
    cyc(100);
    chk("rnd_thresh0", 32'(err_sym_ct_o), 32'd0);
    do_reset();
    thresh_i = 8'd255; err_mask_i = 2'b10;
    cyc(200);
    thresh_i = 8'd100;
    cyc(100);

    // Gapped input: only the 32 valid cycles count, triggers at 15 and 31.
    do_reset();
    mode_i = 2'b01; err_mask_i = 2'b01;
    for (int i = 0; i < 64; i++) begin
      valid_i = (i % 2 == 0);
      sym_i   = 2'(i);
      cyc(1);
    end
    valid_i = 1'b0;
    cyc(2);
    chk("gap_sym_ct", 32'(sym_ct_o), 32'd32);
    chk("gap_err_sym_ct", 32'(err_sym_ct_o), 32'd2);
    valid_i = 1'b1;

    // Reset mid-burst, then the next burst starts again at symbol 15.
    do_reset();
    mode_i = 2'b10; burst_len_i = 4'd5; err_mask_i = 2'b11;
    cyc(17);
    do_reset();
    cyc(16);
    chk("rstburst_err", 32'(err_o), 32'd1);
    chk("rstburst_err_sym_ct", 32'(err_sym_ct_o), 32'd1);
    cyc(8);

    // Symbol counter saturation.
    do_reset();
    mode_i = 2'b00;
    cyc(65540);
    chk("sat_sym_ct", 32'(sym_ct_o), 32'h0000FFFF);

    valid_i = 1'b0;
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
